clock_rate_monitor: RTL and testbench

- Measures the rate of an asynchronous clock-like input (CLK_1MHZ, a divided PCI clock, and similar) against the CLK_21MHZ timebase.
- Counts rising edges of MON_IN over a fixed gate window and reports the count.
- Flags results outside an expected range, flags a stuck input, and raises a sticky FAULT after repeated out-of-range windows.
- Sits beside the clock generation logic as its checker; FAULT feeds board status.

---
 rtl/clock_rate_monitor.sv | 145 ++++++++++++++
 tb/tb_clock_rate_monitor.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_rate_monitor.sv
// Counts rising edges of an asynchronous MON_IN over a fixed CLK_21MHZ gate window and flags rate faults.
// Define CLOCK_RATE_MONITOR_HIST_EN to add the RATE_MIN / RATE_MAX history outputs.
module clock_rate_monitor #(
  parameter int GATE_CYCLES = 2200,
  parameter int CNT_W       = 16,
  parameter int EXP_MIN     = 49,
  parameter int EXP_MAX     = 51,
  parameter int FAIL_LIMIT  = 3
) (
  input  logic             CLK_21MHZ,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             MON_IN,
  input  logic             CLR_FAULT,
  output logic [CNT_W-1:0] RATE,
  output logic             RATE_VALID,
  output logic             IN_RANGE,
  output logic             STUCK,
  output logic             FAULT,
  output logic             BUSY
`ifdef CLOCK_RATE_MONITOR_HIST_EN
  ,
  output logic [CNT_W-1:0] RATE_MIN,
  output logic [CNT_W-1:0] RATE_MAX
`endif
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int FAIL_W = $clog2(FAIL_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

  state_t             state, state_next;
  logic               s1, s2, s3;
  logic               edge_det;
  logic [GATE_W-1:0]  gate;
  logic [CNT_W-1:0]   cnt, cnt_inc;
  logic [31:0]        cnt_wide;
  logic               last_gate, report_now, in_range_new, sets_fault;
  logic [FAIL_W-1:0]  fails, fails_inc;

  // NOTE: reset is synchronous here, so RST is just the highest-priority branch inside the clocked block.
  always_ff @(posedge CLK_21MHZ) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the three flops shift together instead of collapsing into one.
      s1 <= MON_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det     = s2 & ~s3;
  assign cnt_inc      = (edge_det && cnt != '1) ? cnt + CNT_W'(1) : cnt;
  assign cnt_wide     = 32'(cnt_inc);
  assign last_gate    = (gate == GATE_W'(GATE_CYCLES - 1));
  assign report_now   = (state == MEASURE) && ENABLE && last_gate;
  assign in_range_new = (cnt_wide >= 32'(EXP_MIN)) && (cnt_wide <= 32'(EXP_MAX));
  assign fails_inc    = (fails == FAIL_W'(FAIL_LIMIT)) ? fails : fails + FAIL_W'(1);
  assign sets_fault   = report_now && !in_range_new && (fails_inc == FAIL_W'(FAIL_LIMIT));

  always_ff @(posedge CLK_21MHZ) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (ENABLE) state_next = MEASURE;
      MEASURE: begin
        if (!ENABLE)        state_next = IDLE;
        else if (last_gate) state_next = REPORT;
      end
      REPORT:  state_next = ENABLE ? MEASURE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY       = (state == MEASURE) || (state == REPORT);
    RATE_VALID = (state == REPORT);
  end

  // Gate and edge counters only run in MEASURE; IDLE and REPORT leave them cleared for the next window.
  always_ff @(posedge CLK_21MHZ) begin
    if (RST) begin
      gate <= '0;
      cnt  <= '0;
    end else if (state == MEASURE) begin
      gate <= gate + GATE_W'(1);
      cnt  <= cnt_inc;
    end else begin
      gate <= '0;
      cnt  <= '0;
    end
  end

  // Results load on the edge that closes the last gate cycle, so they are already valid during REPORT.
  always_ff @(posedge CLK_21MHZ) begin
    if (RST) begin
      RATE     <= '0;
      IN_RANGE <= 1'b0;
      STUCK    <= 1'b0;
      FAULT    <= 1'b0;
      fails    <= '0;
    end else begin
      if (report_now) begin
        RATE     <= cnt_inc;
        IN_RANGE <= in_range_new;
        STUCK    <= (cnt_inc == '0);
      end
      if (sets_fault) begin
        fails <= FAIL_W'(FAIL_LIMIT);
        FAULT <= 1'b1;
      end else if (CLR_FAULT) begin
        fails <= '0;
        FAULT <= 1'b0;
      end else if (report_now) begin
        fails <= in_range_new ? '0 : fails_inc;
      end
    end
  end

`ifdef CLOCK_RATE_MONITOR_HIST_EN
  // A clear coinciding with a report restarts the history from the current count.
  always_ff @(posedge CLK_21MHZ) begin
    if (RST) begin
      RATE_MIN <= '1;
      RATE_MAX <= '0;
    end else if (report_now) begin
      RATE_MIN <= (CLR_FAULT || cnt_inc < RATE_MIN) ? cnt_inc : RATE_MIN;
      RATE_MAX <= (CLR_FAULT || cnt_inc > RATE_MAX) ? cnt_inc : RATE_MAX;
    end else if (CLR_FAULT) begin
      RATE_MIN <= '1;
      RATE_MAX <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_clock_rate_monitor.sv
// Self-checking bench for clock_rate_monitor: per-cycle reference model plus directed literal pins.
// A second instance with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_clock_rate_monitor;

  localparam int G    = 2200;
  localparam int LIM  = 3;
  localparam int EMIN = 49;
  localparam int EMAX = 51;
  localparam int RMAX = 65535;
  localparam int SAT  = 15;

  logic clk = 1'b0;
  logic rst, en, clr;
  logic mon = 1'b0;

  logic [15:0] rate, rate_min, rate_max;
  logic        rate_valid, in_range, stuck, fault, busy;
  logic [3:0]  rate_s, rate_min_s, rate_max_s;
  logic        valid_s, in_range_s, stuck_s, fault_s, busy_s;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int mon_mode = 1;
  bit mon_const = 1'b0;
  int half_p = 22;
  int seg_id = 0;
  int last_seg = 0;
  int ph_cnt = 0;

  // Reference model state: window position -1 idle, 0..G-1 gate cycle, G report.
  bit model_ok = 1'b0;
  int m_pos = -1;
  int m_cnt = 0;
  int m_fails = 0;
  bit h0, h1, h2;
  int e_rate, e_rate_sat, e_min, e_max;
  bit e_valid, e_in, e_stuck, e_fault, e_busy;

  always #5 clk = ~clk;

  clock_rate_monitor dut (
    .CLK_21MHZ (clk),
    .RST       (rst),
    .ENABLE    (en),
    .MON_IN    (mon),
    .CLR_FAULT (clr),
    .RATE      (rate),
    .RATE_VALID(rate_valid),
    .IN_RANGE  (in_range),
    .STUCK     (stuck),
    .FAULT     (fault),
    .BUSY      (busy)
`ifdef CLOCK_RATE_MONITOR_HIST_EN
    ,
    .RATE_MIN  (rate_min),
    .RATE_MAX  (rate_max)
`endif
  );

  clock_rate_monitor #(.CNT_W(4)) dut_sat (
    .CLK_21MHZ (clk),
    .RST       (rst),
    .ENABLE    (en),
    .MON_IN    (mon),
    .CLR_FAULT (clr),
    .RATE      (rate_s),
    .RATE_VALID(valid_s),
    .IN_RANGE  (in_range_s),
    .STUCK     (stuck_s),
    .FAULT     (fault_s),
    .BUSY      (busy_s)
`ifdef CLOCK_RATE_MONITOR_HIST_EN
    ,
    .RATE_MIN  (rate_min_s),
    .RATE_MAX  (rate_max_s)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitored signal source: constant level, square wave of half period half_p, or per-cycle noise.
  always @(negedge clk) begin
    if (seg_id != last_seg) begin
      last_seg = seg_id;
      ph_cnt   = 0;
    end
    case (mon_mode)
      0: mon = mon_const;
      1: begin
        if (ph_cnt >= half_p - 1) begin
          ph_cnt = 0;
          mon    = ~mon;
        end else begin
          ph_cnt++;
        end
      end
      default: mon = 1'($urandom_range(0, 1));
    endcase
  end

  // Behavioural model: edges are rising transitions of MON_IN as seen two samples late.
  always @(posedge clk) begin
    bit edge_seen, rep;
    int cnt_r, inc;
    if (rst) begin
      model_ok = 1'b1;
      m_pos = -1; m_cnt = 0; m_fails = 0;
      h0 = 0; h1 = 0; h2 = 0;
      e_rate = 0; e_rate_sat = 0; e_min = RMAX; e_max = 0;
      e_valid = 0; e_in = 0; e_stuck = 0; e_fault = 0; e_busy = 0;
    end else begin
      edge_seen = h1 && !h2;
      h2 = h1; h1 = h0; h0 = mon;
      rep = 1'b0;
      cnt_r = 0;
      inc = 0;
      if (m_pos < 0) begin
        if (en) begin m_pos = 0; m_cnt = 0; end
      end else if (m_pos == G) begin
        m_pos = en ? 0 : -1;
        m_cnt = 0;
      end else if (!en) begin
        m_pos = -1;
      end else begin
        if (edge_seen) m_cnt++;
        if (m_pos == G - 1) begin m_pos = G; rep = 1'b1; end
        else m_pos++;
      end
      if (rep) begin
        cnt_r      = (m_cnt > RMAX) ? RMAX : m_cnt;
        e_rate     = cnt_r;
        e_rate_sat = (m_cnt > SAT) ? SAT : m_cnt;
        e_in       = (cnt_r >= EMIN) && (cnt_r <= EMAX);
        e_stuck    = (cnt_r == 0);
        inc        = (m_fails + 1 > LIM) ? LIM : m_fails + 1;
      end
      if (rep && !e_in && inc == LIM) begin
        m_fails = LIM; e_fault = 1'b1;
      end else if (clr) begin
        m_fails = 0; e_fault = 1'b0;
      end else if (rep) begin
        m_fails = e_in ? 0 : inc;
      end
      if (rep) begin
        e_min = (clr || cnt_r < e_min) ? cnt_r : e_min;
        e_max = (clr || cnt_r > e_max) ? cnt_r : e_max;
      end else if (clr) begin
        e_min = RMAX; e_max = 0;
      end
      e_valid = (m_pos == G);
      e_busy  = (m_pos >= 0);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("rate", rate, e_rate);
      check("rate_valid", rate_valid, e_valid);
      check("in_range", in_range, e_in);
      check("stuck", stuck, e_stuck);
      check("fault", fault, e_fault);
      check("busy", busy, e_busy);
      check("rate_sat", rate_s, e_rate_sat);
      check("valid_sat", valid_s, e_valid);
`ifdef CLOCK_RATE_MONITOR_HIST_EN
      check("rate_min", rate_min, e_min);
      check("rate_max", rate_max, e_max);
`endif
    end
  end

  task automatic wait_valid(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rate_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("valid_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, at, at2, rate_hold;
    int bad_pat [5] = '{20, 20, 22, 20, 20};
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_rate", rate, 0);
    check("reset_valid", rate_valid, 0);
    check("reset_fault", fault, 0);
    check("reset_busy", busy, 0);

    // Nominal 21MHz/44 input: 50 edges per window, one report every 2201 cycles.
    repeat (10) @(negedge clk);
    en = 1'b1; k = cyc;
    wait_valid(2300, at);
    check("first_latency", at - k, 1 + G);
    check("nominal_rate", rate, 50);
    check("nominal_in_range", in_range, 1);
    check("sat_rate", rate_s, 15);
`ifdef CLOCK_RATE_MONITOR_HIST_EN
    check("hist_min_first", rate_min, 50);
    check("hist_max_first", rate_max, 50);
`endif
    wait_valid(2300, at2);
    check("window_period", at2 - at, G + 1);
    check("nominal_stuck", stuck, 0);

    // Stuck-high input: zero count, fault on the third window, clear, and again three windows later.
    en = 1'b0; mon_mode = 0; mon_const = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b1;
    for (int w = 1; w <= 6; w++) begin
      wait_valid(2300, at);
      if (w == 1) begin
        check("stuck_rate", rate, 0);
        check("stuck_flag", stuck, 1);
        check("stuck_in_range", in_range, 0);
      end
      check("stuck_fault", fault, (w == 3 || w == 6) ? 1 : 0);
      if (w == 3) begin
        repeat (100) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_fault", fault, 0);
      end
    end

    // Reset mid-window with FAULT set, then restart while MON_IN is high.
    mon_mode = 1; half_p = 22; seg_id++;
    repeat (700) @(negedge clk);
    check("pre_rst_fault", fault, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    check("rst_rate", rate, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    check("rst_stuck", stuck, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i > 5 && mon) break;
    end
    en = 1'b1;
    wait_valid(2300, at);
    check("restart_rate", rate, 50);

    // Bad, bad, good, bad, bad: never three consecutive failures.
    half_p = bad_pat[0];
    for (int w = 0; w < 5; w++) begin
      wait_valid(2300, at);
      check("alt_in_range", in_range, (bad_pat[w] == 22) ? 1 : 0);
      if (w < 4) half_p = bad_pat[w + 1];
    end
    check("alt_fault", fault, 0);

    // Abort at gate cycle 1000, then re-enable and time the next report.
    half_p = 22;
    en = 1'b0;
    repeat (3) @(negedge clk);
    rate_hold = e_rate;
    en = 1'b1; k = cyc;
    repeat (1001) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_rate_hold", rate, rate_hold);
    repeat (20) @(negedge clk);
    check("abort_no_valid", rate_valid, 0);
    en = 1'b1; k = cyc;
    wait_valid(2300, at);
    check("reenable_latency", at - k, 1 + G);

    // Randomized segments; clears are biased toward the report edge to hit the coincidence rules.
    for (int s = 0; s < 10; s++) begin
      int len;
      len = $urandom_range(200, 5000);
      en = ($urandom_range(0, 99) < 85);
      case ($urandom_range(0, 3))
        0: begin mon_mode = 0; mon_const = 1'($urandom_range(0, 1)); end
        1, 2: begin mon_mode = 1; half_p = $urandom_range(18, 24); end
        default: mon_mode = 2;
      endcase
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        clr = ($urandom_range(0, 1999) == 0) || (m_pos == G - 1 && $urandom_range(0, 2) == 0);
        rst = ($urandom_range(0, 9999) == 0);
      end
    end
    clr = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
